// File: rtl/spi_slave_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// spi_slave_pkg : shared SPI constants, FSM state encoding and edge bundle type
// Revision      : 1.0
// ============================================================================
package spi_slave_pkg;

    localparam int unsigned SPI_BITS = 8;
    localparam logic        CPOL     = 1'b1;
    localparam logic        CPHA     = 1'b1;

    localparam int unsigned CNT_W    = $clog2(SPI_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SPI_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_LOAD  = 3'b010,
        ST_TRANS = 3'b100
    } state_t;

    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
    } edge_t;

endpackage : spi_slave_pkg
`default_nettype wire

// File: rtl/spi_slave_edge_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// spi_slave_edge_sync : multi-flop synchroniser with rise/fall pulse detection
// Revision            : 1.0
// ============================================================================
module spi_slave_edge_sync
    import spi_slave_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  async_in,
    output edge_t sync_out
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Reset to the line's idle level so no spurious edge appears after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign sync_out.level = r_sync[SYNC_STAGES-1];
    assign sync_out.rise  =  r_sync[SYNC_STAGES-1] & ~r_prev;
    assign sync_out.fall  = ~r_sync[SYNC_STAGES-1] &  r_prev;

endmodule : spi_slave_edge_sync
`default_nettype wire

// File: rtl/spi_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// spi_slave : CPOL=1/CPHA=1 SPI responder presenting parallel bytes locally.
//             Optional status (rx_overrun/tx_underrun) under SPI_SLAVE_STATUS_EN.
// Revision  : 1.0
// ============================================================================
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int unsigned         SYNC_STAGES = 2,
    parameter logic                IDLE_MISO   = 1'b1,
    parameter logic [SPI_BITS-1:0] DEFAULT_TX  = 8'hFF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SPI_BITS-1:0] tx_byte,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic [SPI_BITS-1:0] rx_byte,
    output logic                rx_valid,
    output logic                busy,
`ifdef SPI_SLAVE_STATUS_EN
    input  logic                rx_ack,
    input  logic                status_clr,
    output logic                rx_overrun,
    output logic                tx_underrun,
`endif
    input  logic                SS,
    input  logic                SCK,
    input  logic                MOSI,
    output logic                MISO
);

    edge_t w_ss;
    edge_t w_sck;
    edge_t w_mosi;
    logic  w_unused;

    spi_slave_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk(clk), .rst_n(rst_n), .async_in(SS), .sync_out(w_ss)
    );
    spi_slave_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sync_sck (
        .clk(clk), .rst_n(rst_n), .async_in(SCK), .sync_out(w_sck)
    );
    spi_slave_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .async_in(MOSI), .sync_out(w_mosi)
    );

    assign w_unused = ^{w_mosi.rise, w_mosi.fall};

    state_t              r_state;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [SPI_BITS-1:0] r_tx_buf;
    logic [SPI_BITS-2:0] r_rx_shift;
    logic [SPI_BITS-1:0] w_tx_next;
    logic                w_byte_done;
    logic                w_load;

    assign w_tx_next   = tx_valid ? tx_byte : DEFAULT_TX;
    // An SS release in the same clk as the 8th rising edge aborts the byte.
    assign w_byte_done = ~w_ss.rise && (r_state == ST_TRANS) && w_sck.rise
                         && (r_bit_cnt == LAST_BIT);
    assign w_load      = ~w_ss.rise && ((r_state == ST_LOAD) || w_byte_done);
    assign busy        = ~w_ss.level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_tx_buf   <= '0;
            r_rx_shift <= '0;
            rx_byte    <= '0;
            rx_valid   <= 1'b0;
            tx_ready   <= 1'b0;
            MISO       <= IDLE_MISO;
        end else begin
            tx_ready <= w_load;
            rx_valid <= w_byte_done;
            if (w_load) begin
                r_tx_buf <= w_tx_next;
                MISO     <= w_tx_next[SPI_BITS-1];
            end
            if (w_ss.rise) begin
                r_state   <= ST_IDLE;
                r_bit_cnt <= '0;
                MISO      <= IDLE_MISO;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_ss.fall) r_state <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        r_bit_cnt <= '0;
                        r_state   <= ST_TRANS;
                    end
                    ST_TRANS: begin
                        if (w_sck.rise) begin
                            r_rx_shift <= {r_rx_shift[SPI_BITS-3:0], w_mosi.level};
                            r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
                            if (r_bit_cnt == LAST_BIT)
                                rx_byte <= {r_rx_shift, w_mosi.level};
                        end else if (w_sck.fall && (r_bit_cnt != '0)) begin
                            // MSB was presented at load time, so the first fall of a byte holds MISO.
                            r_tx_buf <= {r_tx_buf[SPI_BITS-2:0], 1'b0};
                            MISO     <= r_tx_buf[SPI_BITS-2];
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef SPI_SLAVE_STATUS_EN
    logic r_rx_pending;

    // A set in the same cycle as status_clr wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_pending <= 1'b0;
            rx_overrun   <= 1'b0;
            tx_underrun  <= 1'b0;
        end else begin
            if (w_byte_done)
                r_rx_pending <= 1'b1;
            else if (rx_ack)
                r_rx_pending <= 1'b0;

            if (w_byte_done && r_rx_pending && !rx_ack)
                rx_overrun <= 1'b1;
            else if (status_clr)
                rx_overrun <= 1'b0;

            if (w_load && !tx_valid)
                tx_underrun <= 1'b1;
            else if (status_clr)
                tx_underrun <= 1'b0;
        end
    end
`endif

endmodule : spi_slave
`default_nettype wire

// File: tb/tb_spi_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_spi_slave : randomized SPI master + scoreboard for spi_slave
// Revision     : 1.0
// ============================================================================
module tb_spi_slave;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic [7:0] tx_byte  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       busy;
    logic       SS       = 1'b1;
    logic       SCK      = 1'b1;
    logic       MOSI     = 1'b0;
    logic       MISO;

    int nvec = 0;
    int nerr = 0;

    logic [7:0] q_rx[$];     // expected received bytes, in order
    logic [7:0] q_ld[$];     // bytes the slave should be shifting out, in load order
    logic [8:0] q_plan[$];   // {valid, byte} to present at upcoming load points
    logic [7:0] mdl_last_rx = 8'h00;
    int         half_ns     = 80;

    always #5 clk = ~clk;

    spi_slave dut (
        .clk(clk), .rst_n(rst_n),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .busy(busy),
        .SS(SS), .SCK(SCK), .MOSI(MOSI), .MISO(MISO)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic present_next();
        if (q_plan.size() > 0) begin
            {tx_valid, tx_byte} = q_plan[0];
        end else begin
            tx_valid = ($urandom_range(0, 3) != 0);
            tx_byte  = 8'($urandom);
        end
    endtask

    // Local-logic model: every load point consumes what is presented (or 8'hFF on underrun).
    initial forever begin
        @(negedge clk);
        if (rst_n && tx_ready === 1'b1) begin
            q_ld.push_back(tx_valid ? tx_byte : 8'hFF);
            if (q_plan.size() > 0) void'(q_plan.pop_front());
            present_next();
        end
    end

    // Receive monitor
    initial forever begin
        @(negedge clk);
        if (rst_n && rx_valid === 1'b1) begin
            nvec++;
            if (q_rx.size() == 0) begin
                nerr++;
                $display("FAIL rx_valid_unexpected: got pulse with rx_byte %0h expected none", rx_byte);
            end else begin
                logic [7:0] exp;
                exp = q_rx.pop_front();
                if (rx_byte !== exp) begin
                    nerr++;
                    $display("FAIL rx_byte: got %0h expected %0h", rx_byte, exp);
                end
            end
        end
    end

    task automatic xfer_bits(input logic [7:0] mo, input int nbits, output logic [7:0] rd);
        rd = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            SCK  = 1'b0;
            MOSI = mo[7-i];
            #(half_ns);
            SCK      = 1'b1;
            rd[7-i]  = MISO;
            if (i == 7) begin
                q_rx.push_back(mo);
                mdl_last_rx = mo;
            end
            #(half_ns);
        end
    endtask

    task automatic frame_start();
        @(negedge clk);
        #2;
        half_ns = $urandom_range(5, 10) * 10;
        present_next();
        SS = 1'b0;
        #160;
        check("busy_in_frame", busy, 1'b1);
    endtask

    task automatic send_byte(input logic [7:0] mo);
        logic [7:0] rd;
        xfer_bits(mo, 8, rd);
        if (q_ld.size() == 0) begin
            nvec++; nerr++;
            $display("FAIL miso_byte: got %0h expected a loaded byte, none loaded", rd);
        end else begin
            check("miso_byte", rd, q_ld.pop_front());
        end
    endtask

    task automatic frame_end();
        SS = 1'b1;
        #200;
        check("busy_idle", busy, 1'b0);
        check("miso_idle", MISO, 1'b1);
        check("rx_byte_held", rx_byte, mdl_last_rx);
        check("spare_loads", q_ld.size(), 1);
        q_ld.delete();
    endtask

    initial begin
        logic [7:0] rd;
        int nb;
        #22;
        check("rst_tx_ready", tx_ready, 1'b0);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rx_byte", rx_byte, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_miso", MISO, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        #100;

        // Single byte A5 in, 3C out
        q_plan.push_back({1'b1, 8'h3C});
        frame_start(); send_byte(8'hA5); frame_end();

        // Back-to-back bytes
        q_plan.push_back({1'b1, 8'h55});
        q_plan.push_back({1'b1, 8'hAA});
        frame_start(); send_byte(8'h01); send_byte(8'h80); frame_end();

        // Underrun returns the default byte
        q_plan.push_back({1'b0, 8'h12});
        frame_start(); send_byte(8'h7E); frame_end();

        // Abort after 4 bits, then a clean byte
        frame_start(); xfer_bits(8'hF0, 4, rd); frame_end();
        frame_start(); send_byte(8'h0F); frame_end();

        // Reset in the middle of a byte
        frame_start();
        xfer_bits(8'hC3, 4, rd);
        rst_n = 1'b0;
        #1;
        check("midrst_tx_ready", tx_ready, 1'b0);
        check("midrst_rx_valid", rx_valid, 1'b0);
        check("midrst_rx_byte", rx_byte, 8'h00);
        check("midrst_busy", busy, 1'b0);
        check("midrst_miso", MISO, 1'b1);
        SS  = 1'b1;
        SCK = 1'b1;
        q_ld.delete();
        q_plan.delete();
        q_rx.delete();
        mdl_last_rx = 8'h00;
        #50;
        @(negedge clk);
        rst_n = 1'b1;
        #100;
        q_plan.push_back({1'b1, 8'h96});
        frame_start(); send_byte(8'h69); frame_end();

        // Randomized frames, some with aborts
        for (int f = 0; f < 25; f++) begin
            nb = $urandom_range(1, 3);
            frame_start();
            for (int b = 0; b < nb; b++) send_byte(8'($urandom));
            if ($urandom_range(0, 4) == 0) xfer_bits(8'($urandom), $urandom_range(1, 7), rd);
            frame_end();
        end

        check("rx_missing", q_rx.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule : tb_spi_slave
`default_nettype wire
